// File: rtl/gwa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gwa_pkg
//  Purpose  : Shared state encoding and default timing for the coin payout unit
//  Revision : 1.0  initial release
// ============================================================================
package gwa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRE1 = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_FIRE2 = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int SOL_CYC_DEF = 4;
    localparam int TMO_CYC_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/gwa_pend_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : gwa_pend_cnt
//  Purpose  : Saturating 3-bit pending-request counter with drop flag
//  Revision : 1.0  initial release
// ============================================================================
module gwa_pend_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [2:0] o_cnt,
    output logic       o_ovf
);

    logic [2:0] r_cnt;
    logic       w_full;

    assign w_full = (r_cnt == 3'd7);
    // A request met by a same-cycle completion is absorbed, not dropped.
    assign o_ovf  = i_inc & ~i_dec & w_full;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (i_inc & ~i_dec & ~w_full) begin
            r_cnt <= r_cnt + 3'd1;
        end else if (i_dec & ~i_inc & (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/coin_payout.sv
`default_nettype none
// ============================================================================
//  Module   : coin_payout
//  Purpose  : Two-tube coin ejector controller with sensor check and timeout
//  Revision : 1.0  initial release
// ============================================================================
module coin_payout
    import gwa_pkg::*;
#(
    parameter int SOL_CYC = SOL_CYC_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic eu1o,
    input  logic eu2o,
    input  logic s1,
    input  logic s2,
    output logic sol1,
    output logic sol2,
    output logic busy,
    output logic err,
    output logic ovf
);

    localparam logic [7:0] c_sol_last = 8'(SOL_CYC - 1);
    localparam logic [7:0] c_tmo_last = 8'(TMO_CYC - 1);

    state_t     r_state;
    logic [7:0] r_tmr;
    logic       r_seen;
    logic       r_ovf;

    logic [2:0] w_p1;
    logic [2:0] w_p2;
    logic       w_ovf1;
    logic       w_ovf2;
    logic       w_dec1;
    logic       w_dec2;
    logic       w_srv;
    logic       w_oth;

    gwa_pend_cnt u_p1 (
        .clk   (clk),
        .rst   (rst),
        .i_inc (eu1o),
        .i_dec (w_dec1),
        .o_cnt (w_p1),
        .o_ovf (w_ovf1)
    );

    gwa_pend_cnt u_p2 (
        .clk   (clk),
        .rst   (rst),
        .i_inc (eu2o),
        .i_dec (w_dec2),
        .o_cnt (w_p2),
        .o_ovf (w_ovf2)
    );

    // Served / foreign sensor relative to the tube currently being paid out.
    always_comb begin
        w_srv  = 1'b0;
        w_oth  = 1'b0;
        w_dec1 = 1'b0;
        w_dec2 = 1'b0;
        case (r_state)
            ST_FIRE1, ST_WAIT1: begin
                w_srv  = s1;
                w_oth  = s2;
                w_dec1 = s1 & ~s2 & ~r_seen;
            end
            ST_FIRE2, ST_WAIT2: begin
                w_srv  = s2;
                w_oth  = s1;
                w_dec2 = s2 & ~s1 & ~r_seen;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= 8'd0;
            r_seen  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= w_ovf1 | w_ovf2;
            case (r_state)
                ST_IDLE: begin
                    r_tmr  <= 8'd0;
                    r_seen <= 1'b0;
                    if (w_p2 != 3'd0) begin
                        r_state <= ST_FIRE2;
                    end else if (w_p1 != 3'd0) begin
                        r_state <= ST_FIRE1;
                    end
                end
                ST_FIRE1, ST_FIRE2: begin
                    if (w_oth) begin
                        r_state <= ST_ERR;
                    end else if (r_tmr == c_sol_last) begin
                        // A coin already seen during the pulse skips the wait phase.
                        r_tmr <= 8'd0;
                        if (r_seen | w_srv) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= (r_state == ST_FIRE1) ? ST_WAIT1 : ST_WAIT2;
                        end
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                        if (w_srv) begin
                            r_seen <= 1'b1;
                        end
                    end
                end
                ST_WAIT1, ST_WAIT2: begin
                    if (w_oth) begin
                        r_state <= ST_ERR;
                    end else if (w_srv) begin
                        r_state <= ST_IDLE;
                    end else if (r_tmr == c_tmo_last) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sol1 = (r_state == ST_FIRE1);
    assign sol2 = (r_state == ST_FIRE2);
    assign busy = (r_state != ST_IDLE);
    assign err  = (r_state == ST_ERR);
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: doc/coin_payout.md
COIN_PAYOUT -- requirements
Module: coin_payout

Interface
REQ-001 SHALL have parameter SOL_CYC, default 4, solenoid on-time in clk cycles (1..15).
REQ-002 SHALL have parameter TMO_CYC, default 16, wait-for-sensor timeout in clk cycles (1..255).
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port eu1o  input  1  one-cycle request to pay out one 1-Euro coin.
REQ-006 SHALL have port eu2o  input  1  one-cycle request to pay out one 2-Euro coin.
REQ-007 SHALL have port s1  input  1  tube-1 coin-passed sensor, synchronous to clk, high while a coin passes.
REQ-008 SHALL have port s2  input  1  tube-2 coin-passed sensor, same rules as s1.
REQ-009 SHALL have port sol1  output  1  tube-1 ejector solenoid drive.
REQ-010 SHALL have port sol2  output  1  tube-2 ejector solenoid drive.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port err  output  1  high in state ERR.
REQ-013 SHALL have port ovf  output  1  one-cycle pulse when a request is dropped.

Function
REQ-014 SHALL keep pending counters p1 and p2, each 3 bits wide, incremented on eu1o or eu2o respectively and saturating at 7.
REQ-015 SHALL pulse ovf for one cycle, without changing the counter, when a request arrives while its counter is 7; simultaneous eu1o and eu2o overflow gives one ovf pulse.
REQ-016 SHALL leave a counter unchanged when increment and decrement fall in the same cycle.
REQ-017 SHALL implement the Moore FSM states IDLE, FIRE1, WAIT1, FIRE2, WAIT2, ERR.
REQ-018 SHALL, in IDLE, go to FIRE2 if p2>0, else to FIRE1 if p1>0, else stay; 2-Euro coins have priority.
REQ-019 SHALL assert sol1 only in FIRE1 and sol2 only in FIRE2; all outputs are decoded from the state register only (ovf excepted).
REQ-020 SHALL hold FIRE1/FIRE2 for exactly SOL_CYC cycles, then go to WAIT1/WAIT2 and clear the timer.
REQ-021 SHALL treat a high on the served tube's sensor in FIRE or WAIT as success: decrement that counter and return to IDLE at the earliest after FIRE completes (a sensor seen in FIRE sets a flag; FIRE then exits directly to IDLE).
REQ-022 SHALL go to ERR when WAIT has lasted TMO_CYC cycles without the served sensor.
REQ-023 SHALL go to ERR when the non-served tube's sensor is high during FIRE or WAIT.
REQ-024 SHALL ignore s1 and s2 in IDLE and ERR.
REQ-025 SHALL stay in ERR until rst; requests keep being counted in ERR, but none are served.
REQ-026 SHALL give latency: request sampled at edge E0 -> counter updated at E0 -> FIRE entered at E1 -> solenoid high from E1 for SOL_CYC cycles.

Reset
REQ-027 SHALL on rst force state IDLE, p1=p2=0, timer=0, sensor flag=0, and sol1=sol2=busy=err=ovf=0, immediately and independently of clk.
REQ-028 SHALL, when rst is asserted mid-payout, drop the solenoid at once and discard all pending requests.

Structure
REQ-029 SHALL place the state encoding (3-bit) and the default values of SOL_CYC/TMO_CYC in the shared package gwa_pkg.
REQ-030 SHALL implement each pending counter as an instance of the sub-module gwa_pend_cnt (inc, dec, saturating 3-bit count, ovf flag), instantiated twice.

Verification
REQ-031 SHALL cover single eu1o pulse, s1 high 2 cycles after FIRE1 ends -> sol1 high 4 cycles, p1 1->0, back to IDLE, err=0.
REQ-032 SHALL cover eu1o and eu2o in the same cycle with sensors answered -> FIRE2 served first, then FIRE1; p1 and p2 end at 0.
REQ-033 SHALL cover 9 eu2o pulses with no service possible (s2 held low) -> p2 saturates at 7, two ovf pulses, and ERR 4+16 cycles after FIRE2 entry.
REQ-034 SHALL cover s1 high during FIRE2 -> ERR next cycle, sol2 low, err=1, further eu1o still increments p1.
REQ-035 SHALL cover s2 high in FIRE2 cycle 2 -> sol2 still high the full 4 cycles, then IDLE with no WAIT2 cycle.
REQ-036 SHALL cover rst asserted in FIRE1 cycle 3 -> sol1, busy, p1 and p2 at 0 before the next clk edge.
